// File: rtl/edge_fb_pkg.sv
// rtl/edge_fb_pkg.sv - shared frame geometry, FSM states and label codes for the edge frame writer
package edge_fb_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 3;

  typedef enum logic {
    IDLE,
    CAPTURE
  } fb_state_t;

  // Label codes, also used by the display colour map
  localparam logic [DATA_W-1:0] LBL_NONE     = 3'd0;
  localparam logic [DATA_W-1:0] LBL_HORZ     = 3'd1;
  localparam logic [DATA_W-1:0] LBL_VERT     = 3'd2;
  localparam logic [DATA_W-1:0] LBL_DIAG_POS = 3'd3;
  localparam logic [DATA_W-1:0] LBL_DIAG_NEG = 3'd4;

endpackage

// File: rtl/edge_frame_writer_if.sv
// rtl/edge_frame_writer_if.sv - labelled pixel stream in, frame buffer write port and status out
interface edge_frame_writer_if #(
  parameter int ADDR_W = edge_fb_pkg::ADDR_W,
  parameter int DATA_W = edge_fb_pkg::DATA_W
);

  logic              pix_valid;
  logic              pix_sof;
  logic              pix_eol;
  logic [DATA_W-1:0] pix_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_bank;
  logic              disp_bank;
  logic              frame_done;
  logic              frame_err;

  // Pixel source / observer side
  modport master (
    output pix_valid, pix_sof, pix_eol, pix_data,
    input  wr_en, wr_addr, wr_data, wr_bank, disp_bank, frame_done, frame_err
  );

  // Frame writer side
  modport slave (
    input  pix_valid, pix_sof, pix_eol, pix_data,
    output wr_en, wr_addr, wr_data, wr_bank, disp_bank, frame_done, frame_err
  );

endinterface

// File: rtl/frame_pos_counter.sv
// rtl/frame_pos_counter.sv - column/row position and linear address tracker without a multiplier
module frame_pos_counter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int COL_W    = $clog2(H_ACTIVE + 1),
  parameter int ROW_W    = $clog2(V_ACTIVE + 1)
) (
  input  logic              video_clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              adv_pix,
  input  logic              adv_line,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  logic [ADDR_W-1:0] line_base;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic [ADDR_W-1:0] cur_base;
  logic [ADDR_W-1:0] cur_addr;

  // clear rewinds to the frame origin first, so the clearing pixel still advances from 0
  assign cur_col  = clear ? '0 : col;
  assign cur_row  = clear ? '0 : row;
  assign cur_base = clear ? '0 : line_base;
  assign cur_addr = clear ? '0 : addr;

  // Line advance wins over pixel advance; line base steps by H_ACTIVE to form row*H_ACTIVE
  always_ff @(posedge video_clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      line_base <= '0;
      addr      <= '0;
    end else begin
      col       <= adv_line ? '0 : (adv_pix ? cur_col + COL_W'(1) : cur_col);
      row       <= adv_line ? cur_row + ROW_W'(1) : cur_row;
      line_base <= adv_line ? cur_base + LINE_STEP : cur_base;
      addr      <= adv_line ? cur_base + LINE_STEP : (adv_pix ? cur_addr + ADDR_W'(1) : cur_addr);
    end
  end

endmodule

// File: rtl/edge_frame_writer.sv
// rtl/edge_frame_writer.sv - writes validated label frames into a ping-pong frame buffer
module edge_frame_writer
  import edge_fb_pkg::*;
#(
  parameter int H_ACTIVE = edge_fb_pkg::H_ACTIVE,
  parameter int V_ACTIVE = edge_fb_pkg::V_ACTIVE,
  parameter int ADDR_W   = edge_fb_pkg::ADDR_W,
  parameter int DATA_W   = edge_fb_pkg::DATA_W
) (
  input logic                video_clk,
  input logic                reset,
  edge_frame_writer_if.slave bus
);

  localparam int COL_W = $clog2(H_ACTIVE + 1);
  localparam int ROW_W = $clog2(V_ACTIVE + 1);

  localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(V_ACTIVE - 1);

  fb_state_t         state;
  logic              bad;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;
  logic [COL_W-1:0]  eff_col;
  logic [ROW_W-1:0]  eff_row;
  logic [ADDR_W-1:0] eff_addr;
  logic              in_frame;
  logic              fits;
  logic              line_bad;
  logic              bad_next;
  logic              last_line;

  // An SOF pixel is treated as sitting at the frame origin regardless of the old position
  assign eff_col   = bus.pix_sof ? '0 : col;
  assign eff_row   = bus.pix_sof ? '0 : row;
  assign eff_addr  = bus.pix_sof ? '0 : addr;
  assign in_frame  = bus.pix_valid & (bus.pix_sof | (state == CAPTURE));
  assign fits      = eff_col < COL_LIMIT;
  assign line_bad  = bus.pix_eol & (eff_col != COL_LAST);
  assign bad_next  = (~bus.pix_sof & bad) | ~fits | line_bad;
  assign last_line = bus.pix_eol & (eff_row == ROW_LAST);
  assign bus.disp_bank = ~bus.wr_bank;

  frame_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .ADDR_W   (ADDR_W),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_pos (
    .video_clk (video_clk),
    .reset     (reset),
    .clear     (bus.pix_valid & bus.pix_sof),
    .adv_pix   (in_frame & fits),
    .adv_line  (in_frame & bus.pix_eol),
    .col       (col),
    .row       (row),
    .addr      (addr)
  );

  // Capture FSM: registered write port, frame validation and bank swap after a clean frame
  always_ff @(posedge video_clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bad            <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.wr_bank    <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.wr_en      <= in_frame & fits;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      // Swap lands one edge after the done pulse so the final write keeps the old bank
      if (bus.frame_done) begin
        bus.wr_bank <= ~bus.wr_bank;
      end
      if (in_frame) begin
        if (fits) begin
          bus.wr_addr <= eff_addr;
          bus.wr_data <= bus.pix_data;
        end
        if (last_line) begin
          state <= IDLE;
          bad   <= 1'b0;
          if (bad_next) begin
            bus.frame_err <= 1'b1;
          end else begin
            bus.frame_done <= 1'b1;
          end
        end else begin
          state <= CAPTURE;
          bad   <= bad_next;
        end
        // Restart mid-frame throws away the frame in progress
        if (bus.pix_sof && (state == CAPTURE)) begin
          bus.frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_frame_writer.sv
// tb/tb_edge_frame_writer.sv - scoreboard bench for edge_frame_writer on a reduced frame size
module tb_edge_frame_writer;
  import edge_fb_pkg::*;

  localparam int H = 8;
  localparam int V = 4;
  localparam int AW = 19;
  localparam int DW = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wr;
    logic          bank;
    logic          done;
    logic          err;
  } exp_t;

  logic video_clk = 1'b0;
  logic reset     = 1'b1;

  edge_frame_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  edge_frame_writer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW),
    .DATA_W   (DW)
  ) dut (
    .video_clk (video_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 video_clk = ~video_clk;

  exp_t        q[$];
  exp_t        e;
  logic [26:0] got_v;
  logic [26:0] exp_v;
  logic        exp_bank;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [26:0] outs();
    return {bus.wr_en, bus.wr_en ? bus.wr_addr : 19'd0, bus.wr_en ? bus.wr_data : 3'd0,
            bus.wr_bank, bus.disp_bank, bus.frame_done, bus.frame_err};
  endfunction

  function automatic logic [2:0] lbl(input int r, input int c);
    return 3'((r * 3 + c) % 5);
  endfunction

  // Monitor: every cycle with a write or a status pulse must match the next expectation
  always @(negedge video_clk) begin
    if (!reset && (bus.wr_en || bus.frame_done || bus.frame_err)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got wr_en=%0b addr=%0d done=%0b err=%0b, required no activity",
                 bus.wr_en, bus.wr_addr, bus.frame_done, bus.frame_err);
      end else begin
        e     = q.pop_front();
        got_v = outs();
        exp_v = {e.wr, e.wr ? e.addr : 19'd0, e.wr ? e.data : 3'd0, e.bank, ~e.bank, e.done, e.err};
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL write_seq: got wr=%0b addr=%0d data=%0d bank=%0b disp=%0b done=%0b err=%0b, required wr=%0b addr=%0d data=%0d bank=%0b disp=%0b done=%0b err=%0b",
                   got_v[26], got_v[25:7], got_v[6:4], got_v[3], got_v[2], got_v[1], got_v[0],
                   exp_v[26], exp_v[25:7], exp_v[6:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  task automatic px(input bit sof, input bit eol, input logic [2:0] d, input bit wr,
                    input int a, input bit done, input bit err);
    @(posedge video_clk);
    #1;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    bus.pix_eol   = eol;
    bus.pix_data  = d;
    if (wr || done || err) begin
      q.push_back('{addr: AW'(a), data: d, wr: wr, bank: exp_bank, done: done, err: err});
    end
  endtask

  // Valid low with junk on the qualifiers: must be ignored entirely
  task automatic idle();
    @(posedge video_clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'($urandom);
    bus.pix_eol   = 1'($urandom);
    bus.pix_data  = 3'($urandom);
  endtask

  task automatic send_frame(input int bad_row, input bit gaps, input bit restart);
    int g;
    bit first;
    bit last;
    bit bad;
    g   = 0;
    bad = (bad_row >= 0);
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        first = (r == 0) && (c == 0);
        last  = (r == V - 1) && (c == H - 1);
        px(first, (c == H - 1) && (r != bad_row), lbl(r, c), 1'b1, r * H + c,
           last && !bad, (last && bad) || (first && restart));
        if (r == bad_row && c == H - 1) begin
          px(1'b0, 1'b1, LBL_DIAG_NEG, 1'b0, 0, 1'b0, 1'b0);
        end
        if (gaps) begin
          g++;
          if (g == 2) begin
            idle();
            g = 0;
          end
        end
      end
    end
    if (!bad) exp_bank = ~exp_bank;
  endtask

  task automatic send_partial(input int rows, input int cols);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < H; c++) begin
        px((r == 0) && (c == 0), c == H - 1, lbl(r, c), 1'b1, r * H + c, 1'b0, 1'b0);
      end
    end
    for (int c = 0; c < cols; c++) begin
      px((rows == 0) && (c == 0), 1'b0, lbl(rows, c), 1'b1, rows * H + c, 1'b0, 1'b0);
    end
  endtask

  task automatic drain(input string name);
    repeat (4) idle();
    @(negedge video_clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d outstanding writes, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_vec(input string name, input logic [26:0] want);
    checks++;
    got_v = outs();
    if (got_v !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got_v, want);
    end
  endtask

  task automatic check_bank(input string name);
    @(negedge video_clk);
    checks++;
    if ({bus.wr_bank, bus.disp_bank} !== {exp_bank, ~exp_bank}) begin
      errors++;
      $display("FAIL %s_bank: got wr_bank=%0b disp_bank=%0b required wr_bank=%0b disp_bank=%0b",
               name, bus.wr_bank, bus.disp_bank, exp_bank, ~exp_bank);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_eol   = 1'b0;
    bus.pix_data  = '0;
    exp_bank      = 1'b0;
    repeat (3) @(posedge video_clk);
    @(negedge video_clk);
    check_vec("reset_state", {1'b0, 19'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    @(posedge video_clk);
    #1 reset = 1'b0;

    // Pixels before any SOF are dropped
    px(1'b0, 1'b0, LBL_HORZ, 1'b0, 0, 1'b0, 1'b0);
    px(1'b0, 1'b1, LBL_VERT, 1'b0, 0, 1'b0, 1'b0);
    px(1'b0, 1'b0, LBL_DIAG_POS, 1'b0, 0, 1'b0, 1'b0);
    idle();

    send_frame(-1, 1'b0, 1'b0);
    drain("clean");
    check_bank("clean");

    send_frame(-1, 1'b1, 1'b0);
    drain("gaps");
    check_bank("gaps");

    send_frame(1, 1'b0, 1'b0);
    drain("overrun");
    check_bank("overrun");

    send_partial(2, 5);
    send_frame(-1, 1'b0, 1'b1);
    drain("restart");
    check_bank("restart");

    // Asynchronous reset partway through a frame
    send_partial(2, 3);
    drain("pre_reset");
    @(posedge video_clk);
    #3 reset = 1'b1;
    #1 check_vec("async_reset", {1'b0, 19'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    exp_bank = 1'b0;
    repeat (2) @(posedge video_clk);
    #1 reset = 1'b0;

    send_frame(-1, 1'b0, 1'b0);
    drain("post_reset");
    check_bank("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_frame_writer.md
# edge_frame_writer

Writes the edge-detector's 3-bit labelled pixel stream into a ping-pong frame buffer so the VGA display path always reads a complete, stable 640x480 frame. It sits between the edge/label pipeline and the dual-port BRAM; the display path reads the bank named by `disp_bank`. Each pixel's linear address is `row*640 + col`, generated incrementally without a multiplier. Whole frames are validated, and banks swap only after a clean frame.

## Interface
Parameters:
- `H_ACTIVE`, 640: pixels per line.
- `V_ACTIVE`, 480: lines per frame.
- `ADDR_W`, 19: per-bank address width.
- `DATA_W`, 3: label width.

Ports:
- `video_clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `pix_valid`  in  1  pixel present this cycle.
- `pix_sof`  in  1  first pixel of frame; qualified by `pix_valid`.
- `pix_eol`  in  1  last pixel of line; qualified by `pix_valid`.
- `pix_data`  in  DATA_W  label (0 none, 1..4 edge classes).
- `wr_en`  out  1  BRAM write strobe.
- `wr_addr`  out  ADDR_W  per-bank address.
- `wr_data`  out  DATA_W  data to write.
- `wr_bank`  out  1  bank being written; BRAM address is {`wr_bank`, `wr_addr`}.
- `disp_bank`  out  1  bank the display reads.
- `frame_done`  out  1  one-cycle pulse on a clean frame's last write.
- `frame_err`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- States: IDLE (wait for SOF), CAPTURE.
- IDLE: pixels without `pix_sof` are ignored (no write).
- `pix_valid & pix_sof` in any state:
  - col=0, row=0, addr=0; bad-flag cleared; pixel written at addr 0; enter CAPTURE.
  - In CAPTURE this is a mid-frame restart: the old frame is aborted, `frame_err` pulses and no bank swap occurs.
- CAPTURE, valid pixel with col<H_ACTIVE: written at addr; col+1, addr+1.
- Valid pixel with col==H_ACTIVE (line overrun): not written; bad-flag set; col saturates.
- `pix_eol`:
  - If col!=H_ACTIVE-1 (short line or overrun), set bad-flag.
  - Then row+1, col=0, addr=(row+1)*H_ACTIVE, kept as an incremental line-base register.
- `pix_eol` with row==V_ACTIVE-1 ends the frame:
  - Clean (bad-flag clear after this line's check): `frame_done`, banks swap, go IDLE.
  - Bad: `frame_err`, no swap, go IDLE.
- Rows beyond V_ACTIVE are unreachable because the frame ends at row V_ACTIVE-1.
- `pix_sof` and `pix_eol` on the same pixel: SOF handling first, then EOL on row 0. The frame is bad unless H_ACTIVE==1.
- `pix_valid` low: counters and state hold.

## Timing
- `wr_en`, `wr_addr`, `wr_data` are registered: a pixel presented at edge N appears at edge N+1. Latency is 1 cycle; throughput is 1 pixel/cycle.
- `frame_done` / `frame_err` are asserted in the same cycle as the final pixel's write (or in the cycle the abort is registered). Each is high for exactly 1 cycle.
- Swap: `wr_bank` and `disp_bank` toggle at the edge after `frame_done`. The last write of a frame therefore carries the old `wr_bank`. `disp_bank` is always `~wr_bank`.
- Reset values: state IDLE, counters 0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_bank`=0, `disp_bank`=1, `frame_done`=0, `frame_err`=0.
- Reset mid-frame: partial frame discarded, no pulse, banks return to reset values.

## Structure
- Shared package `edge_fb_pkg`:
  - H_ACTIVE, V_ACTIVE, ADDR_W, DATA_W.
  - State enum {IDLE, CAPTURE}.
  - Label code constants shared with the display colour map.
- One natural sub-module, `frame_pos_counter`:
  - Holds col, row, line base and addr.
  - Inputs: clear, advance pixel, advance line.
  - Outputs: col, row, addr.

## Test plan
- Reset, then a clean 640x480 frame (SOF on the first pixel, EOL every 640th) -> 307200 writes at addr 0..307199 with `wr_bank`=0. `frame_done` pulses with the write at 307199; next cycle `wr_bank`=1, `disp_bank`=0.
- Same frame with `pix_valid` deasserted every 3rd cycle -> identical address/data sequence, no extra writes.
- Line 10 sent with 641 pixels -> pixel 641 not written; frame ends with `frame_err` pulse; banks unchanged.
- SOF at row 200, col 5 -> `frame_err` pulse; that pixel written at addr 0 with the same `wr_bank`. A following clean frame -> `frame_done` and swap.
- Pixels sent before any SOF after reset -> no `wr_en` until the SOF pixel, which writes addr 0.
- `reset` asserted at row 300 -> all outputs at reset values asynchronously; the next clean frame writes bank 0.
